// File: rtl/ms_uart_rx_p.sv
// ms_uart_rx_p: oversampling UART receive core with runtime frame format,
// 3-sample majority voting, false-start rejection and per-frame status.
// Received words leave through a valid/ready handshake.
// Optional break detector: define MS_UART_RX_BREAK_EN to build it; when
// undefined brk is tied low and the low-period counter does not exist.
module ms_uart_rx_p #(
  parameter int MDW  = 9,   // maximum data width (5..9)
  parameter int SC_W = 16,  // prescaler width
  parameter int OVS  = 16   // ticks per bit, power of 2, 8..32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en,
  input  logic [SC_W-1:0] prescale,
  input  logic [3:0]      data_bits,
  input  logic [1:0]      parity,
  input  logic            stop2,
  input  logic            RX,
  output logic [MDW-1:0]  rdata,
  output logic            rvalid,
  input  logic            rready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy,
  output logic            brk
);

  localparam int SC_CW = $clog2(OVS);
  localparam logic [SC_CW-1:0] SC_S0   = SC_CW'(OVS/2 - 1);
  localparam logic [SC_CW-1:0] SC_S1   = SC_CW'(OVS/2);
  localparam logic [SC_CW-1:0] SC_DEC  = SC_CW'(OVS/2 + 1);
  localparam logic [SC_CW-1:0] SC_LAST = SC_CW'(OVS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Input synchroniser and edge history
  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic rx_fall;

  // Prescaler
  logic [SC_W-1:0] pre_q, pre_d;
  logic            tick;

  // Frame engine state
  logic [2:0]       state_q, state_d;
  logic [SC_CW-1:0] sc_q, sc_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_idx_q, stop_idx_d;
  logic             s0_q, s0_d, s1_q, s1_d;
  logic [MDW-1:0]   shift_q, shift_d;
  logic             ferr_acc_q, ferr_acc_d;
  logic             perr_acc_q, perr_acc_d;
  logic [3:0]       cfg_bits_q, cfg_bits_d;
  logic [1:0]       cfg_par_q, cfg_par_d;
  logic             cfg_stop2_q, cfg_stop2_d;

  // Output registers
  logic [MDW-1:0] rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;
  logic           frame_err_q, frame_err_d;
  logic           parity_err_q, parity_err_d;
  logic           overrun_q, overrun_d;

  logic vote, decide, sc_last, par_en, par_exp;
  logic brk_block;
  logic [3:0] bits_clamped;

  assign rx_fall = rx_prev_q & ~rx_s_q;
  assign tick    = en && (pre_q == '0);
  assign decide  = tick && (sc_q == SC_DEC);
  assign sc_last = tick && (sc_q == SC_LAST);
  // Third sample is the live synchronised input at the decision tick.
  assign vote    = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign par_en  = cfg_par_q[0] ^ cfg_par_q[1];
  // Even parity expects XOR of data, odd expects XNOR; upper bits are 0.
  assign par_exp = (^shift_q) ^ cfg_par_q[1];

  assign bits_clamped = (data_bits < 4'd5)     ? 4'd5 :
                        (data_bits > 4'(MDW))  ? 4'(MDW) : data_bits;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Prescaler next value: free-running down-counter, parked at 0 when disabled
  always_comb begin
    pre_d = pre_q;
    if (!en)              pre_d = '0;
    else if (pre_q == '0) pre_d = prescale;
    else                  pre_d = pre_q - 1'b1;
  end

  // Frame engine next state and completion / handshake decisions
  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    bit_cnt_d    = bit_cnt_q;
    stop_idx_d   = stop_idx_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    shift_d      = shift_q;
    ferr_acc_d   = ferr_acc_q;
    perr_acc_d   = perr_acc_q;
    cfg_bits_d   = cfg_bits_q;
    cfg_par_d    = cfg_par_q;
    cfg_stop2_d  = cfg_stop2_q;
    rdata_d      = rdata_q;
    rvalid_d     = rvalid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    if (rvalid_q && rready) rvalid_d = 1'b0;

    if (state_q != S_IDLE && tick) begin
      sc_d = sc_last ? '0 : sc_q + 1'b1;
      if (sc_q == SC_S0) s0_d = rx_s_q;
      if (sc_q == SC_S1) s1_d = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        if (en && rx_fall && !brk_block) begin
          state_d     = S_START;
          sc_d        = '0;
          bit_cnt_d   = '0;
          stop_idx_d  = 1'b0;
          shift_d     = '0;
          ferr_acc_d  = 1'b0;
          perr_acc_d  = 1'b0;
          cfg_bits_d  = bits_clamped;
          cfg_par_d   = parity;
          cfg_stop2_d = stop2;
        end
      end
      S_START: begin
        if (decide && vote) state_d = S_IDLE;
        else if (sc_last)   state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          for (int i = 0; i < MDW; i++) begin
            if (bit_cnt_q == 4'(i)) shift_d[i] = vote;
          end
        end
        if (sc_last) begin
          if (bit_cnt_q == cfg_bits_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = par_en ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide)  perr_acc_d = vote ^ par_exp;
        if (sc_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          if (!cfg_stop2_q || stop_idx_q) begin
            // Finish at the last stop bit's decision so the next start edge
            // can be caught even if the stop bit is short.
            state_d      = S_IDLE;
            frame_err_d  = ferr_acc_q | ~vote;
            parity_err_d = perr_acc_q;
            if (!rvalid_q || rready) begin
              rdata_d  = shift_q;
              rvalid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            ferr_acc_d = ferr_acc_q | ~vote;
          end
        end
        if (sc_last && !stop_idx_q) stop_idx_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) state_d = S_IDLE;
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q        <= '0;
      state_q      <= S_IDLE;
      sc_q         <= '0;
      bit_cnt_q    <= '0;
      stop_idx_q   <= 1'b0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shift_q      <= '0;
      ferr_acc_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      cfg_bits_q   <= 4'd8;
      cfg_par_q    <= 2'b00;
      cfg_stop2_q  <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_idx_q   <= stop_idx_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      shift_q      <= shift_d;
      ferr_acc_q   <= ferr_acc_d;
      perr_acc_q   <= perr_acc_d;
      cfg_bits_q   <= cfg_bits_d;
      cfg_par_q    <= cfg_par_d;
      cfg_stop2_q  <= cfg_stop2_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef MS_UART_RX_BREAK_EN
  logic [15:0] low_cnt_q, low_cnt_d;
  logic [15:0] brk_thr;
  logic [4:0]  frame_bits;
  logic        brk_q, brk_d;

  // Break threshold is one full frame (start..stops) of the latched format.
  assign frame_bits = 5'd2 + {1'b0, cfg_bits_q} + {4'd0, par_en} + {4'd0, cfg_stop2_q};
  assign brk_thr    = 16'(frame_bits) * 16'(OVS);

  // Low-period tick counter and break flag; flag drops as rx_s returns high
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (rx_s_q)                          low_cnt_d = '0;
    else if (tick && low_cnt_q != '1)    low_cnt_d = low_cnt_q + 16'd1;
    brk_d = brk_q;
    if (rx_meta_q)                 brk_d = 1'b0;
    else if (low_cnt_q >= brk_thr) brk_d = 1'b1;
  end

  // Break detector registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      low_cnt_q <= '0;
      brk_q     <= 1'b0;
    end else begin
      low_cnt_q <= low_cnt_d;
      brk_q     <= brk_d;
    end
  end

  assign brk       = brk_q;
  assign brk_block = brk_q;
`else
  assign brk       = 1'b0;
  assign brk_block = 1'b0;
`endif

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ms_uart_rx_p.sv
// Testbench for ms_uart_rx_p: directed frames, a frame-level expectation
// queue checked on every clock, and literal pins on key results.
module tb_ms_uart_rx_p;
  localparam int MDW  = 9;
  localparam int SC_W = 16;
  localparam int OVS  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [SC_W-1:0] prescale;
  logic [3:0]      data_bits;
  logic [1:0]      parity;
  logic            stop2;
  logic            RX;
  logic [MDW-1:0]  rdata;
  logic            rvalid;
  logic            rready;
  logic            frame_err;
  logic            parity_err;
  logic            overrun;
  logic            busy;
  logic            brk;

  ms_uart_rx_p #(.MDW(MDW), .SC_W(SC_W), .OVS(OVS)) dut (
    .clk_i(clk), .rst_i(rst), .en(en), .prescale(prescale),
    .data_bits(data_bits), .parity(parity), .stop2(stop2), .RX(RX),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .busy(busy), .brk(brk)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rv_cycles = 0, fe_pulses = 0, pe_pulses = 0, ov_pulses = 0;
  logic brk_allowed = 1'b0;
  int   bt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [8:0] d, input logic f, input logic p, input logic o);
    exp_t e;
    e.data = d; e.ferr = f; e.perr = p; e.ovr = o;
    exp_q.push_back(e);
  endtask

  // Serialise one frame: start, nb data bits LSB first, optional parity,
  // stop bit(s) at stop_val, then two idle bit times. If kill >= 0 the
  // receiver is disabled at the start of that bit index.
  task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] par,
                            input logic s2, input logic bad_par, input logic stop_val,
                            input int kill);
    logic bits [16];
    int   n;
    int   ones;
    logic pbit;
    n = 0; ones = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bits[n++] = d[i];
      if (d[i]) ones++;
    end
    if (par == 2'b01 || par == 2'b10) begin
      // total count of ones (data + parity) even for 01, odd for 10
      pbit = (par == 2'b01) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      bits[n++] = pbit ^ bad_par;
    end
    bits[n++] = stop_val;
    if (s2) bits[n++] = stop_val;
    for (int i = 0; i < n; i++) begin
      RX = bits[i];
      if (i == kill) begin
        chk("busy_before_disable", {31'd0, busy}, 32'd1);
        en = 1'b0;
        wait_clk(2);
        chk("busy_after_disable", {31'd0, busy}, 32'd0);
        wait_clk(bt - 2);
      end else begin
        wait_clk(bt);
      end
    end
    RX = 1'b1;
    wait_clk(2 * bt);
  endtask

  // Compare process: every clock, match completions against the queue
  logic           rv_prev = 1'b0;
  logic           rr_prev = 1'b0;
  logic [MDW-1:0] rd_prev = '0;
  always @(negedge clk) begin
    logic ld;
    exp_t e;
    if (!rst) begin
      ld = rvalid && (!rv_prev || rr_prev);
      if (rvalid)     rv_cycles++;
      if (frame_err)  fe_pulses++;
      if (parity_err) pe_pulses++;
      if (overrun)    ov_pulses++;
      if (ld || overrun) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", {31'd0, ld}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("completion: stored=%0d rdata=0x%0h ferr=%0d perr=%0d ovr=%0d",
                   ld, rdata, frame_err, parity_err, overrun);
          chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          chk("overrun", {31'd0, overrun}, {31'd0, e.ovr});
          if (ld) chk("rdata", {23'd0, rdata}, {23'd0, e.data});
          else    chk("rdata_kept_on_overrun", {23'd0, rdata}, {23'd0, rd_prev});
        end
      end else begin
        chk("stray_pulse", {30'd0, frame_err, parity_err}, 32'd0);
        if (rv_prev && rvalid) chk("rdata_hold", {23'd0, rdata}, {23'd0, rd_prev});
      end
      if (!brk_allowed) chk("brk_idle", {31'd0, brk}, 32'd0);
      rv_prev = rvalid;
      rr_prev = rready;
      rd_prev = rdata;
    end
  end

  initial begin
    int rv0, fe0, pe0, ov0;
    rst = 1'b1; en = 1'b0; RX = 1'b1; rready = 1'b1;
    prescale = 16'd2; data_bits = 4'd8; parity = 2'b00; stop2 = 1'b0;
    bt = (2 + 1) * OVS;
    wait_clk(4);
    chk("rst_rdata", {23'd0, rdata}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_brk", {31'd0, brk}, 32'd0);
    rst = 1'b0;
    wait_clk(2);
    en = 1'b1;
    wait_clk(bt);

    // 8N1 0xA5
    rv0 = rv_cycles; fe0 = fe_pulses; pe0 = pe_pulses;
    expect_frame(9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    chk("t1_rdata", {23'd0, rdata}, 32'h0A5);
    chk("t1_rvalid_cycles", rv_cycles - rv0, 32'd1);
    chk("t1_no_errs", (fe_pulses - fe0) + (pe_pulses - pe0), 32'd0);

    // 7E2 0x35, wrong then correct parity
    data_bits = 4'd7; parity = 2'b01; stop2 = 1'b1;
    pe0 = pe_pulses;
    expect_frame(9'h035, 1'b0, 1'b1, 1'b0);
    send_frame(9'h035, 7, 2'b01, 1'b1, 1'b1, 1'b1, -1);
    chk("t2_bad_par_pulses", pe_pulses - pe0, 32'd1);
    chk("t2_rdata", {23'd0, rdata}, 32'h035);
    pe0 = pe_pulses;
    expect_frame(9'h035, 1'b0, 1'b0, 1'b0);
    send_frame(9'h035, 7, 2'b01, 1'b1, 1'b0, 1'b1, -1);
    chk("t2_good_par_pulses", pe_pulses - pe0, 32'd0);

    // 8N1 framing error then clean frame
    data_bits = 4'd8; parity = 2'b00; stop2 = 1'b0;
    fe0 = fe_pulses;
    expect_frame(9'h03C, 1'b1, 1'b0, 1'b0);
    send_frame(9'h03C, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    chk("t3_frame_err_pulses", fe_pulses - fe0, 32'd1);
    expect_frame(9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(9'h011, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    chk("t3_next_rdata", {23'd0, rdata}, 32'h011);

    // one-tick glitch
    rv0 = rv_cycles;
    RX = 1'b0; wait_clk(3); RX = 1'b1;
    wait_clk(4);
    chk("t4_busy_on_glitch", {31'd0, busy}, 32'd1);
    wait_clk(2 * bt);
    chk("t4_busy_after", {31'd0, busy}, 32'd0);
    chk("t4_no_rvalid", rv_cycles - rv0, 32'd0);

    // overrun with rready low
    rready = 1'b0;
    ov0 = ov_pulses;
    expect_frame(9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(9'h011, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    expect_frame(9'h022, 1'b0, 1'b0, 1'b1);
    send_frame(9'h022, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    chk("t5_rvalid", {31'd0, rvalid}, 32'd1);
    chk("t5_rdata", {23'd0, rdata}, 32'h011);
    chk("t5_overrun_pulses", ov_pulses - ov0, 32'd1);
    rready = 1'b1;
    wait_clk(2);
    chk("t5_rvalid_drop", {31'd0, rvalid}, 32'd0);

    // disable mid-frame: partial frame discarded
    rv0 = rv_cycles;
    send_frame(9'h055, 8, 2'b00, 1'b0, 1'b0, 1'b1, 4);
    en = 1'b1;
    wait_clk(bt);
    chk("t6_no_rvalid", rv_cycles - rv0, 32'd0);

    // 9O1 0x1A3
    data_bits = 4'd9; parity = 2'b10; stop2 = 1'b0;
    expect_frame(9'h1A3, 1'b0, 1'b0, 1'b0);
    send_frame(9'h1A3, 9, 2'b10, 1'b0, 1'b0, 1'b1, -1);
    chk("t7_rdata", {23'd0, rdata}, 32'h1A3);

    // long low: one all-zero frame with framing error, then break (if built)
    data_bits = 4'd8; parity = 2'b00; stop2 = 1'b0;
    expect_frame(9'h000, 1'b1, 1'b0, 1'b0);
    brk_allowed = 1'b1;
    RX = 1'b0;
    wait_clk(20 * bt);
`ifdef MS_UART_RX_BREAK_EN
    chk("t8_brk_high", {31'd0, brk}, 32'd1);
    RX = 1'b1;
    wait_clk(1);
    chk("t8_brk_one_clk", {31'd0, brk}, 32'd1);
    wait_clk(1);
    chk("t8_brk_clear", {31'd0, brk}, 32'd0);
`else
    chk("t8_brk_absent", {31'd0, brk}, 32'd0);
    RX = 1'b1;
    wait_clk(2);
`endif
    brk_allowed = 1'b0;
    wait_clk(2 * bt);
    chk("t8_rdata_zero", {23'd0, rdata}, 32'h000);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_uart_rx_p.md
Name: ms_uart_rx_p

Overview:
- Parametrised UART receiver core: the next generation of the receive path used behind the Wishbone UART.
- Configurable at runtime for 5..MDW data bits, none/even/odd parity and 1 or 2 stop bits.
- Parametrised oversampling with 3-sample majority vote, false-start rejection, and per-frame frame, parity and overrun status.
- Delivers words through a valid/ready handshake to a downstream RX FIFO.

Parameters:
- MDW, 9: maximum data width (5..9); width of rdata.
- SC_W, 16: prescaler width.
- OVS, 16: oversampling ticks per bit; power of 2, 8..32.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- en  in  1  receiver enable.
- prescale  in  SC_W  tick period = prescale+1 clocks.
- data_bits  in  4  data bits per frame, 5..MDW.
- parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  1 = two stop bits.
- RX  in  1  serial input, idle high, asynchronous.
- rdata  out  MDW  received word, right-justified, upper bits 0.
- rvalid  out  1  rdata valid.
- rready  in  1  consumer accepts rdata.
- frame_err  out  1  one-clock pulse, stop bit sampled 0.
- parity_err  out  1  one-clock pulse, parity mismatch.
- overrun  out  1  one-clock pulse, completed word dropped.
- busy  out  1  high in any state except IDLE.
- brk  out  1  break detect (see Optional Feature).

Behaviour:
- Reset values: rdata=0, rvalid=0, frame_err=0, parity_err=0, overrun=0, busy=0, brk=0, synchroniser flops=1, state=IDLE, prescaler=0.
- Synchroniser: RX passes through 2 flops (rx_s). All logic uses rx_s; this adds 2 clocks of latency.
- Prescaler: down-counter reloaded with prescale on reaching 0. tick=1 for one clock at 0. prescale=0 gives a tick every clock. The counter runs freely while en=1 and is held at 0 when en=0.
- Sample counter: sc runs 0..OVS-1 on ticks within each bit. Samples are taken at sc=OVS/2-1, OVS/2 and OVS/2+1. The bit value is the 2-of-3 majority, decided at sc=OVS/2+1.
- Configuration latch: data_bits (clamped to 5..MDW), parity and stop2 are latched on start detection. Changes mid-frame have no effect on the frame in progress.
- IDLE: on rx_s 1->0 with en=1, go to START with sc=0.
- START: if the majority vote is 1, the start is false; return to IDLE with no output. Otherwise, at sc=OVS-1 go to DATA.
- DATA: bits are shifted LSB first. After the latched count of bits, go to PARITY if parity is enabled, else STOP.
- PARITY: compare the sampled bit with the data's XOR (even) or XNOR (odd). At sc=OVS-1 go to STOP.
- STOP: each stop bit is voted. frame_err is set if any stop bit votes 0. With stop2, the first stop bit runs a full OVS ticks. Completion happens at the decision tick of the last stop bit; state returns to IDLE immediately (mid-stop), which allows back-to-back frames.
- Completion, in the clock after the decision tick:
  - If rvalid=0, or rvalid=1 and rready=1: rdata is loaded and rvalid=1.
  - If rvalid=1 and rready=0: rdata is unchanged and overrun pulses.
  - frame_err and parity_err pulse in the same clock whether or not the word was stored.
  - Words with errors are still delivered.
- Handshake: rvalid drops in the clock after rvalid&&rready, unless a completion coincides, in which case it stays 1 with the new data.
- en=0: state is forced to IDLE within 1 clock and a partial frame is discarded. rvalid/rdata hold.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
- Macro: MS_UART_RX_BREAK_EN.
- When defined: a tick counter measures continuous rx_s=0. brk rises once the low period reaches (1+data_bits+parity_en+1+stop2)*OVS ticks and stays high until rx_s=1. A frame completing with rx_s=0 and all-zero data still reports frame_err. No new start is detected while brk=1.
- When undefined: brk is tied 0 and the counter is absent.

Test Plan:
- 8N1, prescale=2, send 0xA5, rready=1 -> rvalid one clock with rdata=0x0A5, no error pulses; bit time = 48 clocks.
- 7E2, send 0x35 with a forced wrong parity bit -> rdata=0x35, parity_err pulse; repeat with correct parity -> no pulse.
- 8N1, send 0x3C with the stop bit driven 0 -> rdata=0x3C with frame_err pulse; the next frame 0x11 is received cleanly.
- 1-tick (3-clock) low glitch on idle RX -> busy returns 0, no rvalid, no errors.
- rready=0, send 0x11 then 0x22 -> rvalid=1, rdata=0x11, overrun pulse at the second completion; rready=1 then -> rvalid drops.
- 9O1, send 0x1A3 -> rdata=0x1A3; with MS_UART_RX_BREAK_EN, hold RX low for 20 bit times -> brk=1, which clears 2 clocks after RX goes high.
